// File: rtl/t05_code_packer.sv
// t05_code_packer
//   Accepts one Huffman code per character (left-justified path bits plus an
//   explicit length) over a valid/ready handshake, serialises the code one bit
//   per cycle and packs the bits MSB-first into WORD_W-bit words. Once the
//   expected character count has been consumed, any partial word is flushed
//   left-aligned and zero-padded.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle pulse, honoured in IDLE/DONE only; latches totChar
//   totChar     number of characters expected in this run
//   code_valid  code_path/code_len valid
//   code_ready  block accepts a code this cycle (ACCEPT state only)
//   code_path   code bits; bit [code_len-1] emitted first, bit 0 last
//   code_len    valid bits in code_path, clamped to MAX_LEN
//   writeBin    strobe: one code bit shifted this cycle
//   bit_out     value of the bit shifted this cycle
//   word_valid  word_data holds a complete or flushed word (registered)
//   word_ready  downstream accepts word; sampled only while word_valid=1
//   word_data   packed word, first bit at MSB
//   word_bits   valid bits in word_data (WORD_W except on flush)
//   busy        run in progress
//   done        run complete; held until next start or reset
//   total_bits  code bits emitted this run
//
// Optional feature
//   T05_PACK_STATS_EN  when defined, total_bits counts writeBin strobes;
//                      otherwise total_bits is tied to zero.

module t05_code_packer #(
  parameter int unsigned MAX_LEN = 128,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             totChar,
  input  logic                         code_valid,
  output logic                         code_ready,
  input  logic [MAX_LEN-1:0]           code_path,
  input  logic [LEN_W-1:0]             code_len,
  output logic                         writeBin,
  output logic                         bit_out,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [WORD_W-1:0]            word_data,
  output logic [$clog2(WORD_W+1)-1:0]  word_bits,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             total_bits
);

  localparam int unsigned WB_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SHIFT,
    S_EMIT,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tot_q, tot_d;
  logic [CNT_W-1:0]   char_cnt_q, char_cnt_d;
  logic [MAX_LEN-1:0] path_q, path_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [WORD_W-1:0]  pack_q, pack_d;
  logic [WB_W-1:0]    pack_cnt_q, pack_cnt_d;
  logic               wvalid_q, wvalid_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [WB_W-1:0]    wbits_q, wbits_d;

  logic               start_go;
  logic               shift_en;
  logic [LEN_W-1:0]   len_c;
  logic               final_char;

  assign start_go   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign len_c      = (code_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : code_len;
  assign final_char = (char_cnt_q == tot_q);

  always_comb begin
    state_d    = state_q;
    tot_d      = tot_q;
    char_cnt_d = char_cnt_q;
    path_d     = path_q;
    rem_d      = rem_q;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    shift_en   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          tot_d      = totChar;
          char_cnt_d = '0;
          pack_cnt_d = '0;
          state_d    = (totChar == '0) ? S_DONE : S_ACCEPT;
        end
      end

      S_ACCEPT: begin
        if (code_valid) begin
          // Left-justify the code so the next bit is always path_q MSB.
          path_d     = code_path << (LEN_W'(MAX_LEN) - len_c);
          rem_d      = len_c;
          char_cnt_d = char_cnt_q + CNT_W'(1);
          if (len_c != '0) begin
            state_d = S_SHIFT;
          end else if (char_cnt_d == tot_q) begin
            // An empty final code with nothing pending skips the flush visit.
            state_d = (pack_cnt_q == '0) ? S_DONE : S_FLUSH;
          end
        end
      end

      S_SHIFT: begin
        shift_en   = 1'b1;
        pack_d     = {pack_q[WORD_W-2:0], path_q[MAX_LEN-1]};
        path_d     = path_q << 1;
        rem_d      = rem_q - LEN_W'(1);
        pack_cnt_d = pack_cnt_q + WB_W'(1);
        if (pack_cnt_d == WB_W'(WORD_W)) begin
          state_d = S_EMIT;
        end else if (rem_q == LEN_W'(1)) begin
          state_d = final_char ? S_FLUSH : S_ACCEPT;
        end
      end

      S_EMIT: begin
        if (word_ready) begin
          pack_cnt_d = '0;
          if (rem_q != '0) begin
            state_d = S_SHIFT;
          end else if (final_char) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end

      S_FLUSH: begin
        if ((pack_cnt_q == '0) || word_ready) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The output word is loaded on the transition into EMIT/FLUSH and holds
    // while the state stalls, since pack_d/pack_cnt_d are unchanged then.
    wvalid_d = 1'b0;
    wdata_d  = '0;
    wbits_d  = '0;
    if (state_d == S_EMIT) begin
      wvalid_d = 1'b1;
      wdata_d  = pack_d;
      wbits_d  = WB_W'(WORD_W);
    end else if ((state_d == S_FLUSH) && (pack_cnt_d != '0)) begin
      wvalid_d = 1'b1;
      wdata_d  = pack_d << (WB_W'(WORD_W) - pack_cnt_d);
      wbits_d  = pack_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tot_q      <= '0;
      char_cnt_q <= '0;
      path_q     <= '0;
      rem_q      <= '0;
      pack_q     <= '0;
      pack_cnt_q <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wbits_q    <= '0;
    end else begin
      state_q    <= state_d;
      tot_q      <= tot_d;
      char_cnt_q <= char_cnt_d;
      path_q     <= path_d;
      rem_q      <= rem_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wbits_q    <= wbits_d;
    end
  end

`ifdef T05_PACK_STATS_EN
  logic [CNT_W-1:0] total_bits_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_bits_q <= '0;
    end else if (start_go) begin
      total_bits_q <= '0;
    end else if (shift_en) begin
      total_bits_q <= total_bits_q + CNT_W'(1);
    end
  end

  assign total_bits = total_bits_q;
`else
  logic unused_stats;
  assign unused_stats = start_go ^ shift_en;
  assign total_bits   = '0;
`endif

  assign code_ready = (state_q == S_ACCEPT);
  assign writeBin   = (state_q == S_SHIFT);
  assign bit_out    = (state_q == S_SHIFT) && path_q[MAX_LEN-1];
  assign word_valid = wvalid_q;
  assign word_data  = wdata_q;
  assign word_bits  = wbits_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_t05_code_packer.sv
module tb_t05_code_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  totChar;
  logic         code_valid;
  logic         code_ready;
  logic [127:0] code_path;
  logic [7:0]   code_len;
  logic         writeBin;
  logic         bit_out;
  logic         word_valid;
  logic         word_ready;
  logic [7:0]   word_data;
  logic [3:0]   word_bits;
  logic         busy;
  logic         done;
  logic [31:0]  total_bits;

  int total = 0;
  int bad   = 0;

  int         nbits = 0;
  logic [7:0] wd_q[$];
  logic [3:0] wb_q[$];

  t05_code_packer #(
    .MAX_LEN (128),
    .WORD_W  (8),
    .CNT_W   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .totChar    (totChar),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_path  (code_path),
    .code_len   (code_len),
    .writeBin   (writeBin),
    .bit_out    (bit_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_bits  (word_bits),
    .busy       (busy),
    .done       (done),
    .total_bits (total_bits)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (writeBin) nbits <= nbits + 1;
    if (word_valid && word_ready) begin
      wd_q.push_back(word_data);
      wb_q.push_back(word_bits);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] n);
    totChar = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input string tag, input logic [127:0] p, input logic [7:0] l);
    int n;
    code_path  = p;
    code_len   = l;
    code_valid = 1'b1;
    n = 0;
    while (!code_ready && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 300), 32'd1);
    tick();
    code_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] exp_stats(input logic [31:0] v);
`ifdef T05_PACK_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  int base_w;
  int base_b;
  int okc;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    totChar    = '0;
    code_valid = 1'b0;
    code_path  = '0;
    code_len   = '0;
    word_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_code_ready", 32'(code_ready), 32'd0);
    chk("rst_writeBin",   32'(writeBin),   32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data",  32'(word_data),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_total_bits", total_bits,      32'd0);
    rst = 1'b1;
    tick();

    // 1: single 4-bit code 1010, flushed as 0xA0 / 4 bits
    base_w = wd_q.size();
    do_start(32'd1);
    chk("t1_code_ready", 32'(code_ready), 32'd1);
    chk("t1_busy",       32'(busy),       32'd1);
    code_path  = 128'b1010;
    code_len   = 8'd4;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("t1_wb0", 32'(writeBin), 32'd1);
    chk("t1_b0",  32'(bit_out),  32'd1);
    tick();
    chk("t1_wb1", 32'(writeBin), 32'd1);
    chk("t1_b1",  32'(bit_out),  32'd0);
    tick();
    chk("t1_b2",  32'(bit_out),  32'd1);
    tick();
    chk("t1_wb3", 32'(writeBin), 32'd1);
    chk("t1_b3",  32'(bit_out),  32'd0);
    tick();
    chk("t1_flush_valid", 32'(word_valid), 32'd1);
    chk("t1_flush_data",  32'(word_data),  32'hA0);
    chk("t1_flush_bits",  32'(word_bits),  32'd4);
    tick();
    chk("t1_done",        32'(done),       32'd1);
    chk("t1_busy_low",    32'(busy),       32'd0);
    chk("t1_nwords",      32'(wd_q.size() - base_w), 32'd1);
    chk("t1_total_bits",  total_bits, exp_stats(32'd4));

    // 2: 10110 + 011 -> exactly one full word 0xB3, no flush word
    base_w = wd_q.size();
    do_start(32'd2);
    send("t2_acc0", 128'b10110, 8'd5);
    send("t2_acc1", 128'b011,   8'd3);
    wait_done("t2_done", 50);
    chk("t2_nwords", 32'(wd_q.size() - base_w), 32'd1);
    chk("t2_data",   32'(wd_q[base_w]), 32'hB3);
    chk("t2_bits",   32'(wb_q[base_w]), 32'd8);
    chk("t2_total_bits", total_bits, exp_stats(32'd8));

    // 3: 10-bit code 1100101001 with word_ready stalled in EMIT for 10 cycles
    base_w = wd_q.size();
    word_ready = 1'b0;
    do_start(32'd1);
    send("t3_acc", 128'b1100101001, 8'd10);
    for (int i = 0; i < 8; i++) tick();
    chk("t3_emit_valid", 32'(word_valid), 32'd1);
    chk("t3_emit_bits",  32'(word_bits),  32'd8);
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_data",  32'(word_data),  32'hCA);
      chk("t3_stall_wb",    32'(writeBin),   32'd0);
      chk("t3_stall_ready", 32'(code_ready), 32'd0);
      tick();
    end
    word_ready = 1'b1;
    tick();
    chk("t3_resume_wb",  32'(writeBin), 32'd1);
    chk("t3_resume_b8",  32'(bit_out),  32'd0);
    tick();
    chk("t3_resume_b9",  32'(bit_out),  32'd1);
    tick();
    chk("t3_flush_data", 32'(word_data), 32'h40);
    chk("t3_flush_bits", 32'(word_bits), 32'd2);
    wait_done("t3_done", 10);
    chk("t3_nwords", 32'(wd_q.size() - base_w), 32'd2);

    // 4: code_len=200 clamps to 128 all-ones bits -> 16 x 0xFF, no flush
    base_w = wd_q.size();
    base_b = nbits;
    do_start(32'd1);
    send("t4_acc", '1, 8'd200);
    wait_done("t4_done", 400);
    chk("t4_nbits",  32'(nbits - base_b), 32'd128);
    chk("t4_nwords", 32'(wd_q.size() - base_w), 32'd16);
    okc = 0;
    for (int i = base_w; i < wd_q.size(); i++)
      if (wd_q[i] == 8'hFF && wb_q[i] == 4'd8) okc++;
    chk("t4_words_ff", 32'(okc), 32'd16);
    chk("t4_total_bits", total_bits, exp_stats(32'd128));

    // 5a: totChar=0 -> done the next cycle, no word
    base_w = wd_q.size();
    do_start(32'd0);
    chk("t5_zero_done",  32'(done),       32'd1);
    chk("t5_zero_valid", 32'(word_valid), 32'd0);
    chk("t5_zero_total", total_bits,      32'd0);
    tick();
    chk("t5_zero_nwords", 32'(wd_q.size() - base_w), 32'd0);

    // 5b: reset mid-run, then a fresh run sees no stale bits
    do_start(32'd3);
    code_path  = 128'b111;
    code_len   = 8'd3;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(code_ready), 32'd0);
    chk("t5_rst_wb",    32'(writeBin),   32'd0);
    chk("t5_rst_bit",   32'(bit_out),    32'd0);
    chk("t5_rst_valid", 32'(word_valid), 32'd0);
    chk("t5_rst_data",  32'(word_data),  32'd0);
    chk("t5_rst_bits",  32'(word_bits),  32'd0);
    chk("t5_rst_busy",  32'(busy),       32'd0);
    chk("t5_rst_done",  32'(done),       32'd0);
    chk("t5_rst_total", total_bits,      32'd0);
    tick();
    rst = 1'b1;
    tick();
    base_w = wd_q.size();
    do_start(32'd1);
    send("t5_acc", 128'b0, 8'd5);
    wait_done("t5_done", 30);
    chk("t5_nwords", 32'(wd_q.size() - base_w), 32'd1);
    chk("t5_data",   32'(wd_q[base_w]), 32'h00);
    chk("t5_bits",   32'(wb_q[base_w]), 32'd5);

    // 6: empty final code with 3 bits pending -> flush 0xA0 / 3 bits
    base_w = wd_q.size();
    do_start(32'd2);
    send("t6_acc0", 128'b101, 8'd3);
    send("t6_acc1", 128'b0,   8'd0);
    wait_done("t6_done", 30);
    chk("t6_nwords", 32'(wd_q.size() - base_w), 32'd1);
    chk("t6_data",   32'(wd_q[base_w]), 32'hA0);
    chk("t6_bits",   32'(wb_q[base_w]), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
